// File: rtl/store_chk_pkg.sv
// Shared types for the store-sequence checker: FSM states, failure cause codes
// and the expected-store table entry.
package store_chk_pkg;

   localparam int ST_XLEN = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } chk_state_t;

   localparam logic [2:0] FC_NONE    = 3'd0;
   localparam logic [2:0] FC_ADDR    = 3'd1;
   localparam logic [2:0] FC_DATA    = 3'd2;
   localparam logic [2:0] FC_TIMEOUT = 3'd3;
   localparam logic [2:0] FC_CFG     = 3'd4;

   typedef struct packed {
      logic [ST_XLEN-1:0] adr;
      logic [ST_XLEN-1:0] data;
   } exp_store_t;

endpackage

// File: rtl/store_exp_table.sv
// Expected-store register file: synchronous write, combinational read.
// Contents are deliberately not reset so a table survives a checker reset.
module store_exp_table
   import store_chk_pkg::*;
#(
   parameter int NUM_EXP = 4,
   parameter int IDX_W   = $clog2(NUM_EXP + 1)
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  exp_store_t       i_wr_entry,
   input  logic [IDX_W-1:0] i_rd_idx,
   output exp_store_t       o_rd_entry
);

   localparam int AW = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
   localparam logic [IDX_W-1:0] NUM_EXP_V = IDX_W'(NUM_EXP);

   exp_store_t r_mem [NUM_EXP];

   logic [AW-1:0] w_wr_a;
   logic [AW-1:0] w_rd_a;
   logic          w_wr_ok;
   logic          w_rd_ok;

   assign w_wr_a  = i_wr_idx[AW-1:0];
   assign w_rd_a  = i_rd_idx[AW-1:0];
   assign w_wr_ok = i_wr_idx < NUM_EXP_V;
   assign w_rd_ok = i_rd_idx < NUM_EXP_V;

   always_ff @(posedge i_clk) begin
      if (i_we && w_wr_ok) begin
         r_mem[w_wr_a] <= i_wr_entry;
      end
   end

   // An out-of-range read can only occur after the run has ended; return zeros.
   assign o_rd_entry = w_rd_ok ? r_mem[w_rd_a] : '0;

endmodule

// File: rtl/store_seq_checker.sv
// Watches the core store port and checks stores against an ordered table of
// expected (address, data) pairs; reports pass, or fail with a cause code.
module store_seq_checker
   import store_chk_pkg::*;
#(
   parameter int XLEN       = ST_XLEN,
   parameter int NUM_EXP    = 4,
   parameter int IGNORE_ADR = 80,
   parameter int TIMEOUT    = 4096,
   parameter int IDX_W      = $clog2(NUM_EXP + 1)
) (
   input  logic                         CLK,
   input  logic                         ResetN,
   input  logic                         Start,
   input  logic                         IgnoreEn,
   input  logic                         CfgWe,
   input  logic [IDX_W-1:0]             CfgIdx,
   input  logic [XLEN-1:0]              CfgAdr,
   input  logic [XLEN-1:0]              CfgData,
   input  logic [IDX_W-1:0]             CfgCount,
   input  logic                         MemWrite,
   input  logic [XLEN-1:0]              DataAdr,
   input  logic [XLEN-1:0]              WriteData,
   output logic                         Done,
   output logic                         Pass,
   output logic                         Fail,
   output logic [2:0]                   FailCode,
   output logic [IDX_W-1:0]             MatchCount,
   output logic [7:0]                   IgnoreCount,
   output logic [XLEN-1:0]              FailAdr,
   output logic [XLEN-1:0]              FailData,
   output logic [$clog2(TIMEOUT+1)-1:0] CycleCount
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [XLEN-1:0]  IGN_ADR_V = XLEN'(IGNORE_ADR);
   localparam logic [CW-1:0]    TIMEOUT_V = CW'(TIMEOUT);
   localparam logic [IDX_W-1:0] NUM_EXP_V = IDX_W'(NUM_EXP);

   chk_state_t       r_state;
   logic             r_done;
   logic             r_pass;
   logic             r_fail;
   logic [2:0]       r_fail_code;
   logic [IDX_W-1:0] r_match;
   logic [7:0]       r_ign;
   logic [XLEN-1:0]  r_fail_adr;
   logic [XLEN-1:0]  r_fail_data;
   logic [CW-1:0]    r_cyc;

   exp_store_t       w_exp;
   exp_store_t       w_cfg_entry;
   logic             w_tbl_we;
   logic [CW-1:0]    w_cyc_next;
   logic [IDX_W-1:0] w_match_next;
   logic             w_is_ign;
   logic             w_adr_hit;
   logic             w_data_hit;
   logic             w_cfg_bad;
   logic             w_timeout;

   assign w_tbl_we     = CfgWe && (r_state != ST_RUN);
   assign w_cfg_entry  = '{adr: CfgAdr, data: CfgData};
   assign w_cyc_next   = r_cyc + CW'(1);
   assign w_match_next = r_match + IDX_W'(1);
   assign w_is_ign     = IgnoreEn && (DataAdr == IGN_ADR_V);
   assign w_adr_hit    = DataAdr == w_exp.adr;
   assign w_data_hit   = WriteData == w_exp.data;
   assign w_cfg_bad    = (CfgCount == '0) || (CfgCount > NUM_EXP_V);
   assign w_timeout    = w_cyc_next == TIMEOUT_V;

   store_exp_table #(
      .NUM_EXP (NUM_EXP),
      .IDX_W   (IDX_W)
   ) u_table (
      .i_clk      (CLK),
      .i_we       (w_tbl_we),
      .i_wr_idx   (CfgIdx),
      .i_wr_entry (w_cfg_entry),
      .i_rd_idx   (r_match),
      .o_rd_entry (w_exp)
   );

   always_ff @(posedge CLK or negedge ResetN) begin
      if (!ResetN) begin
         r_state     <= ST_IDLE;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail      <= 1'b0;
         r_fail_code <= FC_NONE;
         r_match     <= '0;
         r_ign       <= '0;
         r_fail_adr  <= '0;
         r_fail_data <= '0;
         r_cyc       <= '0;
      end else begin
         case (r_state)
            ST_RUN: begin
               r_cyc <= w_cyc_next;
               if (MemWrite && !w_is_ign && w_adr_hit && w_data_hit) begin
                  r_match <= w_match_next;
                  if (w_match_next == CfgCount) begin
                     r_state <= ST_PASS;
                     r_done  <= 1'b1;
                     r_pass  <= 1'b1;
                  end else if (w_timeout) begin
                     r_state     <= ST_FAIL;
                     r_done      <= 1'b1;
                     r_fail      <= 1'b1;
                     r_fail_code <= FC_TIMEOUT;
                  end
               end else if (MemWrite && !w_is_ign) begin
                  // A store outcome beats a timeout landing on the same edge.
                  r_state     <= ST_FAIL;
                  r_done      <= 1'b1;
                  r_fail      <= 1'b1;
                  r_fail_code <= w_adr_hit ? FC_DATA : FC_ADDR;
                  r_fail_adr  <= DataAdr;
                  r_fail_data <= WriteData;
               end else begin
                  if (MemWrite && (r_ign != 8'hFF)) begin
                     r_ign <= r_ign + 8'd1;
                  end
                  if (w_timeout) begin
                     r_state     <= ST_FAIL;
                     r_done      <= 1'b1;
                     r_fail      <= 1'b1;
                     r_fail_code <= FC_TIMEOUT;
                  end
               end
            end
            default: begin
               if (Start) begin
                  r_match     <= '0;
                  r_ign       <= '0;
                  r_cyc       <= '0;
                  r_fail_adr  <= '0;
                  r_fail_data <= '0;
                  r_pass      <= 1'b0;
                  if (w_cfg_bad) begin
                     r_state     <= ST_FAIL;
                     r_done      <= 1'b1;
                     r_fail      <= 1'b1;
                     r_fail_code <= FC_CFG;
                  end else begin
                     r_state     <= ST_RUN;
                     r_done      <= 1'b0;
                     r_fail      <= 1'b0;
                     r_fail_code <= FC_NONE;
                  end
               end
            end
         endcase
      end
   end

   assign Done        = r_done;
   assign Pass        = r_pass;
   assign Fail        = r_fail;
   assign FailCode    = r_fail_code;
   assign MatchCount  = r_match;
   assign IgnoreCount = r_ign;
   assign FailAdr     = r_fail_adr;
   assign FailData    = r_fail_data;
   assign CycleCount  = r_cyc;

endmodule

// File: tb/tb_store_seq_checker.sv
// Bench for store_seq_checker: directed and random check runs, each predicted
// by a reference model and compared by a monitor when Done is presented.
module tb_store_seq_checker;

   localparam int XLEN    = 32;
   localparam int NUM_EXP = 4;
   localparam int IGN     = 80;
   localparam int TIMEOUT = 16;
   localparam int IDX_W   = 3;
   localparam int CW      = 5;

   logic             CLK;
   logic             ResetN;
   logic             Start;
   logic             IgnoreEn;
   logic             CfgWe;
   logic [IDX_W-1:0] CfgIdx;
   logic [XLEN-1:0]  CfgAdr;
   logic [XLEN-1:0]  CfgData;
   logic [IDX_W-1:0] CfgCount;
   logic             MemWrite;
   logic [XLEN-1:0]  DataAdr;
   logic [XLEN-1:0]  WriteData;
   logic             Done;
   logic             Pass;
   logic             Fail;
   logic [2:0]       FailCode;
   logic [IDX_W-1:0] MatchCount;
   logic [7:0]       IgnoreCount;
   logic [XLEN-1:0]  FailAdr;
   logic [XLEN-1:0]  FailData;
   logic [CW-1:0]    CycleCount;

   store_seq_checker #(
      .XLEN(XLEN), .NUM_EXP(NUM_EXP), .IGNORE_ADR(IGN), .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK(CLK), .ResetN(ResetN), .Start(Start), .IgnoreEn(IgnoreEn),
      .CfgWe(CfgWe), .CfgIdx(CfgIdx), .CfgAdr(CfgAdr), .CfgData(CfgData),
      .CfgCount(CfgCount), .MemWrite(MemWrite), .DataAdr(DataAdr),
      .WriteData(WriteData), .Done(Done), .Pass(Pass), .Fail(Fail),
      .FailCode(FailCode), .MatchCount(MatchCount), .IgnoreCount(IgnoreCount),
      .FailAdr(FailAdr), .FailData(FailData), .CycleCount(CycleCount)
   );

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- types, model state, scoreboard ----------------
   typedef struct packed {
      logic             cfg;
      logic             pass;
      logic             fail;
      logic [2:0]       code;
      logic [IDX_W-1:0] match;
      logic [7:0]       ign;
      logic [XLEN-1:0]  fadr;
      logic [XLEN-1:0]  fdata;
      logic [CW-1:0]    cyc;
      logic [7:0]       lat;
   } res_t;

   typedef struct {
      logic             mw;
      logic [XLEN-1:0]  adr;
      logic [XLEN-1:0]  data;
      logic             cw;
      logic [IDX_W-1:0] cidx;
      logic [XLEN-1:0]  cadr;
      logic [XLEN-1:0]  cdata;
   } step_t;

   res_t            exp_q[$];
   step_t           steps[$];
   logic [XLEN-1:0] m_adr  [NUM_EXP];
   logic [XLEN-1:0] m_data [NUM_EXP];
   int              n_checks = 0;
   int              n_fail   = 0;

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: walk the stimulus cycle by cycle applying the checker rules.
   function automatic res_t model(input bit ign_en, input int count);
      res_t  r;
      step_t s;
      int    mc;
      r  = '0;
      mc = 0;
      if (count == 0 || count > NUM_EXP) begin
         r.cfg = 1'b1; r.fail = 1'b1; r.code = 3'd4;
         return r;
      end
      for (int k = 1; k <= TIMEOUT; k++) begin
         s = '{mw: 1'b0, adr: '0, data: '0, cw: 1'b0, cidx: '0, cadr: '0, cdata: '0};
         if (k - 1 < steps.size()) s = steps[k-1];
         r.cyc = CW'(k);
         r.lat = 8'(k);
         if (s.mw) begin
            if (ign_en && s.adr == XLEN'(IGN)) begin
               if (r.ign != 8'd255) r.ign = r.ign + 8'd1;
            end else if (s.adr == m_adr[mc] && s.data == m_data[mc]) begin
               mc++;
               r.match = IDX_W'(mc);
               if (mc == count) begin
                  r.pass = 1'b1;
                  return r;
               end
            end else begin
               r.fail  = 1'b1;
               r.code  = (s.adr == m_adr[mc]) ? 3'd2 : 3'd1;
               r.fadr  = s.adr;
               r.fdata = s.data;
               return r;
            end
         end
         if (k == TIMEOUT) begin
            r.fail = 1'b1;
            r.code = 3'd3;
            return r;
         end
      end
      return r;
   endfunction

   // ---------------- monitor ----------------
   bit start_seen = 1'b0;
   bit armed      = 1'b0;
   int lat_cnt    = 0;

   always @(posedge CLK) begin
      if (ResetN && Start) start_seen = 1'b1;
   end

   initial begin
      res_t e;
      forever begin
         @(negedge CLK);
         if (!ResetN) begin
            armed = 1'b0;
            start_seen = 1'b0;
         end else begin
            if (start_seen) begin
               start_seen = 1'b0;
               armed = 1'b1;
               lat_cnt = 0;
            end else if (armed) begin
               lat_cnt++;
            end
            if (armed && Done) begin
               armed = 1'b0;
               if (exp_q.size() == 0) begin
                  chk("unexpected_done", 32'(exp_q.size()), 32'd1);
               end else begin
                  e = exp_q.pop_front();
                  chk("done",      XLEN'(Done),      XLEN'(e.pass | e.fail));
                  chk("pass",      XLEN'(Pass),      XLEN'(e.pass));
                  chk("fail",      XLEN'(Fail),      XLEN'(e.fail));
                  chk("fail_code", XLEN'(FailCode),  XLEN'(e.code));
                  chk("fail_adr",  FailAdr,          e.fadr);
                  chk("fail_data", FailData,         e.fdata);
                  chk("latency",   XLEN'(lat_cnt),   XLEN'(e.lat));
                  if (!e.cfg) begin
                     chk("match_count",  XLEN'(MatchCount),  XLEN'(e.match));
                     chk("ignore_count", XLEN'(IgnoreCount), XLEN'(e.ign));
                     chk("cycle_count",  XLEN'(CycleCount),  XLEN'(e.cyc));
                  end
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_step(input step_t s);
      MemWrite  = s.mw;   DataAdr = s.adr;   WriteData = s.data;
      CfgWe     = s.cw;   CfgIdx  = s.cidx;  CfgAdr    = s.cadr;  CfgData = s.cdata;
   endtask

   function automatic step_t mk(input logic mw, input int adr, input int data);
      step_t s;
      s = '{mw: mw, adr: XLEN'(adr), data: XLEN'(data), cw: 1'b0, cidx: '0, cadr: '0, cdata: '0};
      return s;
   endfunction

   task automatic add_store(input int adr, input int data);
      steps.push_back(mk(1'b1, adr, data));
   endtask

   task automatic add_idle(input int n);
      for (int i = 0; i < n; i++) steps.push_back(mk(1'b0, 0, 0));
   endtask

   task automatic add_cfg(input int idx, input int adr, input int data);
      step_t s;
      s = mk(1'b0, 0, 0);
      s.cw = 1'b1; s.cidx = IDX_W'(idx); s.cadr = XLEN'(adr); s.cdata = XLEN'(data);
      steps.push_back(s);
   endtask

   // Called at a negedge outside RUN; writes beyond the table are dropped.
   task automatic load_entry(input int idx, input int adr, input int data);
      CfgWe = 1'b1; CfgIdx = IDX_W'(idx); CfgAdr = XLEN'(adr); CfgData = XLEN'(data);
      @(negedge CLK);
      CfgWe = 1'b0;
      if (idx < NUM_EXP) begin
         m_adr[idx]  = XLEN'(adr);
         m_data[idx] = XLEN'(data);
      end
   endtask

   task automatic run_case(input bit ign_en, input int count);
      exp_q.push_back(model(ign_en, count));
      IgnoreEn = ign_en;
      CfgCount = IDX_W'(count);
      Start = 1'b1;
      @(negedge CLK);
      Start = 1'b0;
      foreach (steps[i]) begin
         if (Done) break;
         drive_step(steps[i]);
         @(negedge CLK);
      end
      drive_step(mk(1'b0, 0, 0));
      for (int w = 0; w < 40 && !Done; w++) @(negedge CLK);
      chk("run_reached_done", XLEN'(Done), XLEN'(1));
      @(negedge CLK);
      steps.delete();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_done"},  XLEN'(Done),        '0);
      chk({tag, "_pass"},  XLEN'(Pass),        '0);
      chk({tag, "_fail"},  XLEN'(Fail),        '0);
      chk({tag, "_code"},  XLEN'(FailCode),    '0);
      chk({tag, "_match"}, XLEN'(MatchCount),  '0);
      chk({tag, "_ign"},   XLEN'(IgnoreCount), '0);
      chk({tag, "_fadr"},  FailAdr,            '0);
      chk({tag, "_fdata"}, FailData,           '0);
      chk({tag, "_cyc"},   XLEN'(CycleCount),  '0);
   endtask

   function automatic int pick_adr();
      return 80 + 4 * int'($urandom_range(0, 3));
   endfunction

   task automatic rand_case();
      int cnt, ptr, len, r;
      bit ie;
      for (int j = 0; j < 3; j++)
         load_entry(int'($urandom_range(0, 5)), pick_adr(), int'($urandom_range(0, 3)));
      cnt = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 5)
                                        : int'($urandom_range(1, 4));
      ie  = 1'($urandom_range(0, 1));
      ptr = 0;
      len = int'($urandom_range(1, 10));
      for (int i = 0; i < len; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 25) add_idle(1);
         else if (r < 40) add_store(IGN, int'($urandom_range(0, 255)));
         else if (r < 85 && ptr < NUM_EXP) begin
            add_store(int'(m_adr[ptr]), int'(m_data[ptr]));
            ptr++;
         end else if (r < 95) add_store(pick_adr(), int'($urandom_range(0, 3)));
         else add_cfg(int'($urandom_range(0, 4)), pick_adr(), int'($urandom_range(0, 3)));
      end
      run_case(ie, cnt);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      ResetN = 1'b0; Start = 1'b0; IgnoreEn = 1'b0; CfgCount = '0;
      drive_step(mk(1'b0, 0, 0));
      repeat (2) @(negedge CLK);
      check_all_zero("reset");
      ResetN = 1'b1;
      @(negedge CLK);
      check_all_zero("idle");
      load_entry(0, 84, 71);
      load_entry(1, 88, 5);
      load_entry(2, 92, 1);
      load_entry(3, 80, 2);

      // Happy path with interleaved scratch stores.
      add_store(80, 1); add_store(84, 71); add_store(80, 2); add_store(88, 5);
      run_case(1'b1, 2);
      // Data mismatch on first entry.
      add_store(84, 70);
      run_case(1'b1, 1);
      // Scratch address is a real mismatch when skipping is disabled.
      add_store(80, 3);
      run_case(1'b0, 1);
      // Timeout, then a matching store and a mismatching store on the timeout edge.
      run_case(1'b1, 1);
      add_idle(TIMEOUT - 1); add_store(84, 71);
      run_case(1'b1, 1);
      add_idle(TIMEOUT - 1); add_store(84, 9);
      run_case(1'b1, 1);
      // Ignored store on the timeout edge does not prevent the timeout.
      add_idle(TIMEOUT - 1); add_store(80, 4);
      run_case(1'b1, 1);
      // Config errors, the second from FAIL with Done already high.
      run_case(1'b1, 0);
      run_case(1'b1, 5);
      // Table write during RUN is dropped; write beyond the table is dropped.
      add_cfg(0, 84, 99); add_idle(1); add_store(84, 71);
      run_case(1'b1, 1);
      load_entry(4, 12, 34);
      add_store(84, 71); add_store(88, 5); add_store(92, 1); add_store(80, 2);
      run_case(1'b0, 4);
      // Ignore takes priority over an expected entry at the scratch address.
      add_store(84, 71); add_store(88, 5); add_store(92, 1); add_store(80, 2);
      run_case(1'b1, 4);

      // Async reset mid-RUN, between clock edges.
      IgnoreEn = 1'b1; CfgCount = 3'd2; Start = 1'b1;
      @(negedge CLK);
      Start = 1'b0;
      drive_step(mk(1'b1, 84, 71));
      @(negedge CLK);
      drive_step(mk(1'b0, 0, 0));
      @(posedge CLK);
      #2 ResetN = 1'b0;
      #1 check_all_zero("async_reset");
      @(negedge CLK);
      ResetN = 1'b1;
      @(negedge CLK);
      add_store(80, 1); add_store(84, 71); add_store(88, 5);
      run_case(1'b1, 2);

      for (int n = 0; n < 40; n++) rand_case();

      chk("queue_drained", XLEN'(exp_q.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/store_seq_checker.md
Name: store_seq_checker

Overview:
Parametrised store-sequence checker that replaces ad-hoc single-store pass/fail checks around the RISC-V top. It watches the core's data-memory write port and compares stores against an ordered table of up to NUM_EXP expected (address, data) pairs, loaded at run time. Stores to one designated scratch address are skipped. It reports pass, or fail with a cause code, a cycle budget (timeout) and the offending store.

Parameters:
XLEN, 32, width of address and data buses
NUM_EXP, 4, depth of the expected-store table (>=1)
IGNORE_ADR, 80, store address skipped when IgnoreEn=1
TIMEOUT, 4096, max RUN cycles before a timeout fail (>=1)
IDX_W, $clog2(NUM_EXP+1), width of index and count fields (derived; do not override)

Ports:
CLK  in  1  system clock, rising edge
ResetN  in  1  asynchronous active-low reset
Start  in  1  one-cycle pulse: begin a check run
IgnoreEn  in  1  enable skipping of IGNORE_ADR stores
CfgWe  in  1  table write strobe (honoured in IDLE, PASS, FAIL only)
CfgIdx  in  IDX_W  table entry to write
CfgAdr  in  XLEN  expected store address
CfgData  in  XLEN  expected store data
CfgCount  in  IDX_W  number of active table entries
MemWrite  in  1  core store strobe
DataAdr  in  XLEN  core store address
WriteData  in  XLEN  core store data
Done  out  1  high in PASS or FAIL
Pass  out  1  high in PASS
Fail  out  1  high in FAIL
FailCode  out  3  0 none, 1 addr mismatch, 2 data mismatch, 3 timeout, 4 config error
MatchCount  out  IDX_W  expected stores matched so far
IgnoreCount  out  8  ignored stores, saturating at 255
FailAdr  out  XLEN  DataAdr of the failing store (0 on timeout or config error)
FailData  out  XLEN  WriteData of the failing store (0 on timeout or config error)
CycleCount  out  $clog2(TIMEOUT+1)  cycles spent in RUN

Behaviour:
- Reset (ResetN=0, async): state IDLE; every output 0; table contents undefined, not cleared.
- States are IDLE, RUN, PASS, FAIL. All outputs are registered; one cycle latency from the sampling edge.
- Table write: on the rising edge with CfgWe=1, not in RUN, and CfgIdx<NUM_EXP, the entry is written. Otherwise the write is dropped.
- Start in IDLE, PASS or FAIL:
  - CfgCount==0 or CfgCount>NUM_EXP: go to FAIL with FailCode=4.
  - Otherwise go to RUN and clear MatchCount, IgnoreCount, CycleCount, FailCode, FailAdr and FailData.
- Start in RUN has no effect.
- RUN, each rising edge:
  - CycleCount increments.
  - If MemWrite=1:
    a) If IgnoreEn=1 and DataAdr==IGNORE_ADR, IgnoreCount increments (saturating). This takes priority even if the expected entry has the same address.
    b) Else if DataAdr==exp[MatchCount].adr and WriteData==exp[MatchCount].data, MatchCount increments. If the new MatchCount==CfgCount, go to PASS.
    c) Else if the address matches but the data does not, go to FAIL with code 2 and capture FailAdr/FailData.
    d) Else go to FAIL with code 1 and capture FailAdr/FailData.
  - Timeout: if no transition occurs and CycleCount reaches TIMEOUT, go to FAIL with code 3.
  - A store outcome on the same edge as the timeout wins over the timeout.
- PASS and FAIL hold all status and ignore MemWrite until the next Start or reset.
- Compare rules: full XLEN equality, unsigned. X/Z on inputs is not treated specially in RTL.
- Reset mid-RUN aborts immediately to IDLE; no status is preserved.

Decomposition:
- Package store_chk_pkg holds:
  - the state enum (IDLE/RUN/PASS/FAIL);
  - the FailCode localparams (FC_NONE, FC_ADDR, FC_DATA, FC_TIMEOUT, FC_CFG);
  - a packed struct exp_store_t {adr, data}, XLEN-wide.
- One sub-module, store_exp_table: NUM_EXP-entry register file with a synchronous write port and a combinational read port indexed by MatchCount.
- FSM, counters and capture registers stay in the top module.

Test Plan:
- Happy path: load CfgCount=2, exp0={84,71}, exp1={88,5}; IgnoreEn=1; Start; send stores 80/x, 84/71, 80/x, 88/5 -> Pass=1 one cycle after the last store; MatchCount=2; IgnoreCount=2; FailCode=0.
- Data mismatch: exp0={84,71}; send store 84/70 -> Fail=1, FailCode=2, FailAdr=84, FailData=70, MatchCount=0.
- Ignore disabled: IgnoreEn=0, exp0={84,71}; send store 80/3 -> FailCode=1, FailAdr=80.
- Timeout with collision: TIMEOUT=16, no stores -> FailCode=3 with CycleCount=16. Rerun with the matching last store on the timeout edge -> Pass=1, FailCode=0.
- Config error and locked writes:
  - CfgCount=0 then Start -> FailCode=4 next cycle.
  - CfgWe during RUN does not alter the table: a later expected store still matches the old value.
- Async reset: assert ResetN=0 mid-RUN between clock edges -> all outputs 0 immediately. After release, Start with the retained table runs normally to Pass.
